// File: rtl/cpu_pkg.sv
// Shared pipeline types: hazard control bundle, hazard FSM states, default latencies.
package cpu_pkg;

    localparam int WB_DEPTH = 2;
    localparam int MUL_LAT  = 3;

    typedef struct packed {
        logic stall_if;
        logic hold_idex;
        logic bubble_idex;
        logic bubble_exwb;
    } hz_ctrl_t;

    typedef enum logic [0:0] {
        IDLE,
        MUL_EXEC
    } hz_state_e;

endpackage

// File: rtl/hz_scoreboard.sv
// Per-register pending-writeback countdowns; flags RAW hazards for the ID instruction.
// Counters drain every cycle regardless of stalls; a new write keeps the longer of old/new.
module hz_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int WB_DEPTH = cpu_pkg::WB_DEPTH,
    parameter int MUL_LAT  = cpu_pkg::MUL_LAT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        id_valid_i,
    input  logic [$clog2(NUM_REGS)-1:0] rs1_i,
    input  logic [$clog2(NUM_REGS)-1:0] rs2_i,
    input  logic [$clog2(NUM_REGS)-1:0] rd_i,
    input  logic                        wr_vld_i,
    input  logic                        is_mul_i,
    output logic                        raw_o,
    output logic [NUM_REGS-1:0]         pend_mask_o
);

    localparam int CW = $clog2(WB_DEPTH + MUL_LAT);
    localparam logic [CW-1:0] N_ALU = CW'(WB_DEPTH);
    localparam logic [CW-1:0] N_MUL = CW'(WB_DEPTH + MUL_LAT - 1);

    logic [CW-1:0] cnt_q [NUM_REGS];
    logic [CW-1:0] cnt_d [NUM_REGS];
    logic [CW-1:0] n_load;

    always_comb begin
        n_load = is_mul_i ? N_MUL : N_ALU;
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CW'(1) : '0;
        end
        // Register 0 is never written, so its counter stays at zero forever.
        if (wr_vld_i && (rd_i != '0)) begin
            cnt_d[rd_i] = (cnt_d[rd_i] > n_load) ? cnt_d[rd_i] : n_load;
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (reset) begin
                cnt_q[r] <= '0;
            end else begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            pend_mask_o[r] = (cnt_q[r] != '0);
        end
        raw_o = id_valid_i &&
                (((rs1_i != '0) && (cnt_q[rs1_i] != '0)) ||
                 ((rs2_i != '0) && (cnt_q[rs2_i] != '0)));
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: RAW stalls from the scoreboard, MUL sequencing FSM.
// Controls are combinational from state + ID inputs; MUL_EXEC outranks RAW stalls.
module hazard_ctrl #(
    parameter int NUM_REGS = 32,
    parameter int WB_DEPTH = cpu_pkg::WB_DEPTH,
    parameter int MUL_LAT  = cpu_pkg::MUL_LAT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        id_valid,
    input  logic [$clog2(NUM_REGS)-1:0] id_rs1,
    input  logic [$clog2(NUM_REGS)-1:0] id_rs2,
    input  logic [$clog2(NUM_REGS)-1:0] id_rd,
    input  logic                        id_we,
    input  logic                        id_is_mul,
    output logic                        stall_if,
    output logic                        hold_idex,
    output logic                        bubble_idex,
    output logic                        bubble_exwb,
    output logic                        mul_busy,
    output logic [NUM_REGS-1:0]         pend_mask
);

    import cpu_pkg::*;

    localparam int MCW = $clog2(MUL_LAT + 1);

    hz_state_e          state_q, state_d;
    logic [MCW-1:0]     mcnt_q, mcnt_d;
    hz_ctrl_t           ctrl;
    logic               busy;
    logic               issue;
    logic               raw;
    logic [NUM_REGS-1:0] sb_mask;

    hz_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .WB_DEPTH (WB_DEPTH),
        .MUL_LAT  (MUL_LAT)
    ) u_sb (
        .clk         (clk),
        .reset       (reset),
        .id_valid_i  (id_valid),
        .rs1_i       (id_rs1),
        .rs2_i       (id_rs2),
        .rd_i        (id_rd),
        .wr_vld_i    (issue && id_we),
        .is_mul_i    (id_is_mul),
        .raw_o       (raw),
        .pend_mask_o (sb_mask)
    );

    always_comb begin
        state_d = state_q;
        mcnt_d  = mcnt_q;
        ctrl    = '0;
        busy    = 1'b0;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (raw) begin
                    ctrl.stall_if    = 1'b1;
                    ctrl.bubble_idex = 1'b1;
                end else begin
                    issue = id_valid;
                end
                if (issue && id_is_mul && (MUL_LAT > 1)) begin
                    state_d = MUL_EXEC;
                    mcnt_d  = MCW'(MUL_LAT - 1);
                end
            end
            MUL_EXEC: begin
                ctrl.stall_if    = 1'b1;
                ctrl.hold_idex   = 1'b1;
                ctrl.bubble_exwb = 1'b1;
                busy             = 1'b1;
                mcnt_d           = mcnt_q - MCW'(1);
                if (mcnt_q <= MCW'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Reset silences every output and blocks issue in the same cycle.
        if (reset) begin
            ctrl  = '0;
            busy  = 1'b0;
            issue = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            mcnt_q  <= mcnt_d;
        end
    end

    assign stall_if    = ctrl.stall_if;
    assign hold_idex   = ctrl.hold_idex;
    assign bubble_idex = ctrl.bubble_idex;
    assign bubble_exwb = ctrl.bubble_exwb;
    assign mul_busy    = busy;
    assign pend_mask   = reset ? '0 : sb_mask;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with defaults NUM_REGS=32, WB_DEPTH=2, MUL_LAT=3.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_we, id_is_mul;
    logic        stall_if, hold_idex, bubble_idex, bubble_exwb, mul_busy;
    logic [31:0] pend_mask;

    int tests = 0;
    int fails = 0;

    // Control vector order: {stall_if, hold_idex, bubble_idex, bubble_exwb, mul_busy}
    localparam logic [4:0] C_IDLE = 5'b00000;
    localparam logic [4:0] C_RAW  = 5'b10100;
    localparam logic [4:0] C_MUL  = 5'b11011;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rd       (id_rd),
        .id_we       (id_we),
        .id_is_mul   (id_is_mul),
        .stall_if    (stall_if),
        .hold_idex   (hold_idex),
        .bubble_idex (bubble_idex),
        .bubble_exwb (bubble_exwb),
        .mul_busy    (mul_busy),
        .pend_mask   (pend_mask)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic we, input logic mul);
        id_valid  = v;
        id_rs1    = rs1;
        id_rs2    = rs2;
        id_rd     = rd;
        id_we     = we;
        id_is_mul = mul;
        #2;
    endtask

    task automatic chk_ctl(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {stall_if, hold_idex, bubble_idex, bubble_exwb, mul_busy};
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s ctl obs=%b exp=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_pend(input string tag, input logic [31:0] exp);
        tests++;
        assert (pend_mask === exp) else begin
            fails++;
            $error("FAIL %s pend obs=%h exp=%h", tag, pend_mask, exp);
        end
    endtask

    task automatic drain();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) tick();
    endtask

    initial begin
        reset = 1'b1;
        set_id(1'b1, 5'd3, 5'd0, 5'd3, 1'b1, 1'b1);
        chk_ctl("rst_hi", C_IDLE);
        chk_pend("rst_hi", 32'h0);
        tick();
        tick();
        reset = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk_ctl("post_rst", C_IDLE);
        chk_pend("post_rst", 32'h0);

        // RAW on ALU result
        tick(); set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
        chk_ctl("raw_c0", C_IDLE);
        tick(); set_id(1'b1, 5'd3, 5'd4, 5'd6, 1'b1, 1'b0);
        chk_ctl("raw_c1", C_RAW);  chk_pend("raw_c1", 32'h8);
        tick(); chk_ctl("raw_c2", C_RAW);  chk_pend("raw_c2", 32'h8);
        tick(); chk_ctl("raw_c3", C_IDLE); chk_pend("raw_c3", 32'h0);
        tick(); set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk_pend("raw_c4", 32'h40);
        drain();

        // MUL sequencing with independent follower
        set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1);
        chk_ctl("mul_c0", C_IDLE);
        tick(); set_id(1'b1, 5'd1, 5'd2, 5'd8, 1'b1, 1'b0);
        chk_ctl("mul_c1", C_MUL); chk_pend("mul_c1", 32'h20);
        tick(); chk_ctl("mul_c2", C_MUL);
        tick(); chk_ctl("mul_c3", C_IDLE); chk_pend("mul_c3", 32'h20);
        tick(); set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk_pend("mul_c4", 32'h120);
        drain();

        // Consumer of MUL result
        set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1);
        chk_ctl("dep_c0", C_IDLE);
        tick(); set_id(1'b1, 5'd5, 5'd0, 5'd9, 1'b1, 1'b0);
        chk_ctl("dep_c1", C_MUL);
        tick(); chk_ctl("dep_c2", C_MUL);
        tick(); chk_ctl("dep_c3", C_RAW);
        tick(); chk_ctl("dep_c4", C_RAW);
        tick(); chk_ctl("dep_c5", C_IDLE); chk_pend("dep_c5", 32'h0);
        tick(); set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk_pend("dep_c6", 32'h200);
        drain();

        // Register 0 and invalid instructions
        set_id(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
        chk_ctl("r0_c0", C_IDLE);
        tick(); set_id(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0);
        chk_ctl("r0_c1", C_IDLE); chk_pend("r0_c1", 32'h0);
        tick(); set_id(1'b0, 5'd4, 5'd4, 5'd4, 1'b1, 1'b1);
        chk_ctl("inv_c2", C_IDLE); chk_pend("inv_c2", 32'h10);
        tick(); chk_ctl("inv_c3", C_IDLE); chk_pend("inv_c3", 32'h10);
        tick(); chk_pend("inv_c4", 32'h0);
        drain();

        // Reset in the second MUL_EXEC cycle
        set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1);
        chk_ctl("rm_c0", C_IDLE);
        tick(); set_id(1'b1, 5'd5, 5'd0, 5'd11, 1'b1, 1'b0);
        chk_ctl("rm_c1", C_MUL);
        tick(); reset = 1'b1; #1;
        chk_ctl("rm_c2", C_IDLE); chk_pend("rm_c2", 32'h0);
        tick(); reset = 1'b0; #1;
        chk_ctl("rm_c3", C_IDLE); chk_pend("rm_c3", 32'h0);
        tick(); set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk_ctl("rm_c4", C_IDLE); chk_pend("rm_c4", 32'h800);
        drain();

        // WAW: MUL r7, ALU r7 after MUL_EXEC, then read r7
        set_id(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1);
        chk_ctl("waw_c0", C_IDLE);
        tick(); set_id(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0);
        chk_ctl("waw_c1", C_MUL);
        tick(); chk_ctl("waw_c2", C_MUL);
        tick(); chk_ctl("waw_c3", C_IDLE); chk_pend("waw_c3", 32'h80);
        tick(); set_id(1'b1, 5'd7, 5'd0, 5'd12, 1'b1, 1'b0);
        chk_ctl("waw_c4", C_RAW);
        tick(); chk_ctl("waw_c5", C_RAW); chk_pend("waw_c5", 32'h80);
        tick(); chk_ctl("waw_c6", C_IDLE); chk_pend("waw_c6", 32'h0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
